// File: rtl/rr_pkt_arbiter_pkg.sv
// Shared types and the rotating-priority pick function for the packet arbiter.
package rr_pkt_arbiter_pkg;

    localparam int unsigned MAX_REQ  = 64;
    localparam int unsigned MAX_ID_W = 6;
    localparam int unsigned SUM_W    = MAX_ID_W + 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // First set request scanning ptr, ptr+1, ... wrapping at n; ptr must be < n.
    function automatic logic [MAX_ID_W-1:0] rr_pick(
        input logic [MAX_REQ-1:0]  req,
        input logic [MAX_ID_W-1:0] ptr,
        input int unsigned         n
    );
        logic [MAX_ID_W-1:0] win;
        logic [SUM_W-1:0]    sum;
        logic [MAX_ID_W-1:0] idx;
        logic                found;
        win   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            sum = SUM_W'(ptr) + SUM_W'(k);
            if (32'(sum) >= n) begin
                sum = sum - SUM_W'(n);
            end
            idx = sum[MAX_ID_W-1:0];
            if ((k < n) && !found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/rr_prio_picker.sv
// Combinational rotating-priority picker: request vector + pointer -> winner index.
module rr_prio_picker
    import rr_pkt_arbiter_pkg::*;
#(
    parameter  int unsigned N    = 16,
    localparam int unsigned ID_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [ID_W-1:0] idx_c,
    output logic            any_req_c
);

    logic [MAX_REQ-1:0]  req_ext;
    logic [MAX_ID_W-1:0] ptr_ext;
    logic [MAX_ID_W-1:0] win;

    always_comb begin
        req_ext   = MAX_REQ'(req);
        ptr_ext   = MAX_ID_W'(ptr);
        win       = rr_pick(req_ext, ptr_ext, N);
        idx_c     = ID_W'(win);
        any_req_c = |req;
    end

endmodule

// File: rtl/rr_pkt_arbiter.sv
// Packet-level round-robin arbiter: locks a grant per packet and muxes it
// into a registered output slice tagged with the source index.
module rr_pkt_arbiter
    import rr_pkt_arbiter_pkg::*;
#(
    parameter  int unsigned NUM_REQUESTORS = 16,
    parameter  int unsigned DATA_W         = 64,
    localparam int unsigned ID_W           = (NUM_REQUESTORS > 1) ? $clog2(NUM_REQUESTORS) : 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_REQUESTORS-1:0]          s_valid_i,
    input  logic [NUM_REQUESTORS*DATA_W-1:0]   s_data_i,
    input  logic [NUM_REQUESTORS-1:0]          s_last_i,
    output logic [NUM_REQUESTORS-1:0]          s_ready_o,
    output logic                               m_valid_o,
    output logic [DATA_W-1:0]                  m_data_o,
    output logic                               m_last_o,
    output logic [ID_W-1:0]                    m_id_o,
    input  logic                               m_ready_i
);

    localparam int unsigned LAST_IDX = NUM_REQUESTORS - 1;

    arb_state_t        state_q, state_d;
    logic [ID_W-1:0]   grant_q, grant_d;
    logic [ID_W-1:0]   prio_ptr_q, prio_ptr_d;
    logic              m_valid_d;
    logic [DATA_W-1:0] m_data_d;
    logic              m_last_d;
    logic [ID_W-1:0]   m_id_d;

    logic [ID_W-1:0]   pick_idx;
    logic              pick_any;
    logic              slice_free;
    logic              accept;
    logic              sel_valid;
    logic              sel_last;
    logic [DATA_W-1:0] sel_data;
    logic [DATA_W-1:0] data_arr [NUM_REQUESTORS];

    for (genvar i = 0; i < NUM_REQUESTORS; i++) begin : g_unpack
        assign data_arr[i] = s_data_i[i*DATA_W +: DATA_W];
    end

    rr_prio_picker #(
        .N (NUM_REQUESTORS)
    ) u_picker (
        .req       (s_valid_i),
        .ptr       (prio_ptr_q),
        .idx_c     (pick_idx),
        .any_req_c (pick_any)
    );

    // Next-state, grant lock, ready steering and output-slice load/drain.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        prio_ptr_d = prio_ptr_q;
        m_valid_d  = m_valid_o;
        m_data_d   = m_data_o;
        m_last_d   = m_last_o;
        m_id_d     = m_id_o;
        s_ready_o  = '0;
        accept     = 1'b0;
        slice_free = !m_valid_o || m_ready_i;
        sel_valid  = s_valid_i[grant_q];
        sel_last   = s_last_i[grant_q];
        sel_data   = data_arr[grant_q];

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                s_ready_o[grant_q] = slice_free;
                accept             = sel_valid && slice_free;
                if (accept && sel_last) begin
                    state_d    = IDLE;
                    prio_ptr_d = (32'(grant_q) == LAST_IDX) ? '0 : grant_q + ID_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept) begin
            m_valid_d = 1'b1;
            m_data_d  = sel_data;
            m_last_d  = sel_last;
            m_id_d    = grant_q;
        end else if (m_ready_i) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            prio_ptr_q <= '0;
            m_valid_o  <= 1'b0;
            m_data_o   <= '0;
            m_last_o   <= 1'b0;
            m_id_o     <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            prio_ptr_q <= prio_ptr_d;
            m_valid_o  <= m_valid_d;
            m_data_o   <= m_data_d;
            m_last_o   <= m_last_d;
            m_id_o     <= m_id_d;
        end
    end

endmodule
